// File: rtl/dcache_wb_pkg.sv
// Shared types for the write-back data cache: controller state encoding and
// the helper that rebuilds a memory word address from tag/index/word fields.
package dcache_wb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        FETCH = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } dcache_state_t;

    // Fields arrive zero-extended; the shift amounts come from the cache geometry.
    function automatic logic [31:0] join_addr(input logic [31:0] tag,
                                              input logic [31:0] idx,
                                              input logic [31:0] word,
                                              input int          idx_sh,
                                              input int          tag_sh);
        return (tag << tag_sh) | (idx << idx_sh) | (word << 2);
    endfunction

endpackage

// File: rtl/dcache_frame_array.sv
// Tag/valid/dirty/data storage with one LRU bit per set.
// One write port for hits and fills, one for flush clears; reads are combinational.
module dcache_frame_array
    import dcache_wb_pkg::*;
#(
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int BLKWORDS = 2,
    parameter int TW       = 26,
    parameter int IB       = 3,
    parameter int OW       = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IB-1:0]            rd_set,
    input  logic                     rd_way,
    input  logic [OW-1:0]            rd_word,
    output logic [WAYS-1:0]          rd_valid,
    output logic [WAYS-1:0]          rd_dirty,
    output logic [WAYS-1:0][TW-1:0]  rd_tag,
    output logic                     rd_lru,
    output logic [31:0]              rd_data,
    input  logic [IB-1:0]            wr_set,
    input  logic                     wr_way,
    input  logic [OW-1:0]            wr_word,
    input  logic                     data_we,
    input  logic [31:0]              wr_data,
    input  logic                     meta_we,
    input  logic [TW-1:0]            wr_tag,
    input  logic                     wr_valid,
    input  logic                     wr_dirty,
    input  logic                     lru_we,
    input  logic                     lru_val,
    input  logic                     clr_en,
    input  logic [IB-1:0]            clr_set,
    input  logic                     clr_way
);

    logic [TW-1:0]   tag_q   [SETS][WAYS];
    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] dirty_q [SETS];
    logic [31:0]     data_q  [SETS][WAYS][BLKWORDS];
    logic [SETS-1:0] lru_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
            lru_q <= '0;
        end else begin
            if (meta_we) begin
                valid_q[wr_set][wr_way] <= wr_valid;
                dirty_q[wr_set][wr_way] <= wr_dirty;
            end
            if (clr_en) begin
                valid_q[clr_set][clr_way] <= 1'b0;
                dirty_q[clr_set][clr_way] <= 1'b0;
            end
            if (lru_we) begin
                lru_q[wr_set] <= lru_val;
            end
        end
    end

    // Tags and data are only meaningful under a valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (meta_we) begin
            tag_q[wr_set][wr_way] <= wr_tag;
        end
        if (data_we) begin
            data_q[wr_set][wr_way][wr_word] <= wr_data;
        end
    end

    always_comb begin
        rd_valid = valid_q[rd_set];
        rd_dirty = dirty_q[rd_set];
        rd_lru   = lru_q[rd_set];
        rd_data  = data_q[rd_set][rd_way][rd_word];
        for (int w = 0; w < WAYS; w++) begin
            rd_tag[w] = tag_q[rd_set][w];
        end
    end

endmodule

// File: rtl/dcache_wb.sv
// Write-back, write-allocate set-associative data cache for one CPU, with a
// halt-driven flush that writes every dirty block back before raising flushed.
module dcache_wb
    import dcache_wb_pkg::*;
#(
    parameter int CPUID    = 0,
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);

    localparam int OB  = $clog2(BLKWORDS);
    localparam int IB  = $clog2(SETS);
    localparam int TW  = 30 - OB - IB;
    localparam int OW  = (OB > 0) ? OB : 1;
    localparam int NF  = SETS * WAYS;
    localparam int FW  = $clog2(NF) + 1;
    localparam int WSH = (WAYS == 2) ? 1 : 0;
    // The channel number only matters to the caches wrapper.
    localparam int unused_cpuid = CPUID;

    dcache_state_t state, next_state;

    logic [OW-1:0] word_cnt;
    logic [FW-1:0] fl_cnt;
    logic          halt_pend;
    logic [IB-1:0] xfer_set;
    logic [TW-1:0] req_tag_q, vic_tag;
    logic          vic_way;

    logic [TW-1:0] req_tag;
    logic [IB-1:0] req_set;
    logic [OW-1:0] req_off;
    logic          req, unused_byte;

    logic [IB-1:0]           rd_set;
    logic                    rd_way;
    logic [OW-1:0]           rd_word;
    logic [WAYS-1:0]         rd_valid, rd_dirty;
    logic [WAYS-1:0][TW-1:0] rd_tag;
    logic                    rd_lru;
    logic [31:0]             rd_data;

    logic          hit_any, hit_way, victim, vic_dirty;
    logic          last_word, xfer_done;
    logic [IB-1:0] fl_set;
    logic          fl_way, fl_dirty, fl_last, fl_step;

    logic [IB-1:0] wr_set, clr_set;
    logic [OW-1:0] wr_word;
    logic [TW-1:0] wr_tag;
    logic [31:0]   wr_data;
    logic          wr_way, data_we, meta_we, wr_valid, wr_dirty;
    logic          lru_we, lru_val, clr_en, clr_way;

    assign req_tag     = dmemaddr[31 -: TW];
    assign req_set     = dmemaddr[2+OB +: IB];
    assign req         = dmemREN | dmemWEN;
    assign unused_byte = ^dmemaddr[1:0];

    if (OB > 0) begin : g_off
        assign req_off = dmemaddr[2 +: OW];
    end else begin : g_no_off
        assign req_off = '0;
    end

    // Flush walks frames set-major, way-minor.
    assign fl_set    = IB'(fl_cnt >> WSH);
    assign fl_way    = (WAYS == 2) ? fl_cnt[0] : 1'b0;
    assign fl_dirty  = rd_valid[fl_way] & rd_dirty[fl_way];
    assign fl_last   = (fl_cnt == FW'(NF - 1));
    assign last_word = (word_cnt == OW'(BLKWORDS - 1));
    assign xfer_done = !dwait && last_word;
    assign fl_step   = !fl_dirty || xfer_done;

    always_comb begin
        rd_set  = xfer_set;
        rd_way  = vic_way;
        rd_word = word_cnt;
        if (state == IDLE) begin
            rd_set  = req_set;
            rd_way  = hit_way;
            rd_word = req_off;
        end else if (state == FLUSH) begin
            rd_set = fl_set;
            rd_way = fl_way;
        end
    end

    // Victim preference: lowest-numbered invalid way, otherwise the LRU way.
    always_comb begin
        hit_any = 1'b0;
        hit_way = 1'b0;
        victim  = (WAYS == 2) ? rd_lru : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rd_valid[w] && rd_tag[w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = 1'(w);
            end
            if (!rd_valid[w]) begin
                victim = 1'(w);
            end
        end
        vic_dirty = rd_valid[victim] & rd_dirty[victim];
    end

    dcache_frame_array #(
        .SETS(SETS), .WAYS(WAYS), .BLKWORDS(BLKWORDS), .TW(TW), .IB(IB), .OW(OW)
    ) u_frames (
        .clk(CLK), .rst(RST),
        .rd_set(rd_set), .rd_way(rd_way), .rd_word(rd_word),
        .rd_valid(rd_valid), .rd_dirty(rd_dirty), .rd_tag(rd_tag),
        .rd_lru(rd_lru), .rd_data(rd_data),
        .wr_set(wr_set), .wr_way(wr_way), .wr_word(wr_word),
        .data_we(data_we), .wr_data(wr_data),
        .meta_we(meta_we), .wr_tag(wr_tag), .wr_valid(wr_valid), .wr_dirty(wr_dirty),
        .lru_we(lru_we), .lru_val(lru_val),
        .clr_en(clr_en), .clr_set(clr_set), .clr_way(clr_way)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            word_cnt  <= '0;
            fl_cnt    <= '0;
            halt_pend <= 1'b0;
            xfer_set  <= '0;
            req_tag_q <= '0;
            vic_tag   <= '0;
            vic_way   <= 1'b0;
        end else begin
            if (state == IDLE && req && !hit_any) begin
                xfer_set  <= req_set;
                req_tag_q <= req_tag;
                vic_way   <= victim;
                vic_tag   <= rd_tag[victim];
            end
            if ((state == WB || state == FETCH) && halt) begin
                halt_pend <= 1'b1;
            end
            if ((dREN || dWEN) && !dwait) begin
                word_cnt <= last_word ? '0 : word_cnt + OW'(1);
            end
            if (state == FLUSH && fl_step) begin
                fl_cnt <= fl_cnt + FW'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (!hit_any) next_state = vic_dirty ? WB : FETCH;
                end else if (halt) begin
                    next_state = FLUSH;
                end
            end
            WB:      if (xfer_done) next_state = (halt || halt_pend) ? FLUSH : FETCH;
            FETCH:   if (xfer_done) next_state = (halt || halt_pend) ? FLUSH : IDLE;
            FLUSH:   if (fl_step && fl_last) next_state = DONE;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        dhit     = (state == IDLE) && req && hit_any;
        dmemload = dhit ? rd_data : '0;
        flushed  = (state == DONE);
        dREN     = (state == FETCH);
        dWEN     = (state == WB) || (state == FLUSH && fl_dirty);
        dstore   = dWEN ? rd_data : '0;
        daddr    = '0;
        unique case (state)
            WB:      daddr = join_addr(32'(vic_tag), 32'(xfer_set), 32'(word_cnt), 2 + OB, 2 + OB + IB);
            FETCH:   daddr = join_addr(32'(req_tag_q), 32'(xfer_set), 32'(word_cnt), 2 + OB, 2 + OB + IB);
            FLUSH:   if (fl_dirty) daddr = join_addr(32'(rd_tag[fl_way]), 32'(fl_set), 32'(word_cnt), 2 + OB, 2 + OB + IB);
            default: daddr = '0;
        endcase

        wr_set   = xfer_set;
        wr_way   = vic_way;
        wr_word  = word_cnt;
        wr_data  = dload;
        wr_tag   = req_tag_q;
        wr_valid = 1'b1;
        wr_dirty = 1'b0;
        data_we  = 1'b0;
        meta_we  = 1'b0;
        lru_we   = 1'b0;
        lru_val  = 1'b0;
        clr_en   = (state == FLUSH) && fl_dirty && xfer_done;
        clr_set  = fl_set;
        clr_way  = fl_way;
        if (dhit) begin
            wr_set  = req_set;
            wr_way  = hit_way;
            lru_we  = 1'b1;
            lru_val = (WAYS == 2) ? ~hit_way : 1'b0;
            if (dmemWEN) begin
                wr_word  = req_off;
                wr_data  = dmemstore;
                wr_tag   = req_tag;
                wr_dirty = 1'b1;
                data_we  = 1'b1;
                meta_we  = 1'b1;
            end
        end else if (state == FETCH && !dwait) begin
            data_we = 1'b1;
            meta_we = last_word;
            lru_we  = last_word;
            lru_val = (WAYS == 2) ? ~vic_way : 1'b0;
        end else if (state == WB && xfer_done) begin
            // Victim is clean once written back, so a halt-diverted flush skips it.
            wr_tag  = vic_tag;
            meta_we = 1'b1;
        end
    end

endmodule
